if_id_skid_stage: RTL and testbench

Parametrised fetch-to-decode pipeline stage register with a valid/ready handshake and a two-entry skid buffer. Fetch can keep issuing for one cycle after decode deasserts ready without losing an instruction. Supports decode-side stall and flush; flush inserts a configurable bubble instruction. Sits between the fetch unit and the decoder. Width parameters allow reuse for later stage boundaries.

---
 rtl/if_id_skid_stage_pkg.sv | 15 +
 rtl/if_id_skid_stage.sv | 114 +++++++++++
 tb/tb_if_id_skid_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_stage_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary registers.
//   occ_e    : occupancy state of a two-entry skid stage (EMPTY/ONE/FULL);
//              the encoding doubles as the entry count
//   NOP_FILL : bit pattern repeated to form the default bubble instruction
package if_id_skid_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam logic NOP_FILL = 1'b0;

endpackage

// File: rtl/if_id_skid_stage.sv
// Fetch-to-decode pipeline register with a valid/ready handshake and a
// two-entry skid buffer, decode-side stall/flush and a starvation counter.
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready/in_instr/in_pc8    : fetch side (in_ready is registered)
//   out_valid/out_ready/out_instr/out_pc8: decode side, head entry
//   stall, flush                         : decode hold / kill all entries
//   occupancy                            : held entries 0..2
//   bubble_cnt                           : saturating count of starved cycles
module if_id_skid_stage
  import if_id_skid_stage_pkg::*;
#(
  parameter int unsigned              INSTR_W     = 32,
  parameter int unsigned              PC_W        = 32,
  parameter logic [INSTR_W-1:0]       FLUSH_INSTR = {INSTR_W{NOP_FILL}},
  parameter int unsigned              CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc8,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc8,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int unsigned ENTRY_W = INSTR_W + PC_W;

  occ_e               state_q, state_d;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;
  logic [CNT_W-1:0]   bub_q;
  logic               push;
  logic               pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~stall;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides every other event
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = FULL;
          else if (pop && !push) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs are pure functions of the registered state, so in_ready never
  // depends combinationally on out_ready.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
    occupancy = state_q;
  end

  // Entry storage. main_q drives the outputs and keeps its last contents
  // when the stage drains, so out_instr/out_pc8 hold on empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= {FLUSH_INSTR, {PC_W{1'b0}}};
      skid_q <= '0;
    end else if (flush) begin
      main_q <= {FLUSH_INSTR, main_q[PC_W-1:0]};
      skid_q <= '0;
    end else begin
      unique case (state_q)
        EMPTY: if (push) main_q <= {in_instr, in_pc8};
        ONE: begin
          if (push && pop)       main_q <= {in_instr, in_pc8};
          else if (push && !pop) skid_q <= {in_instr, in_pc8};
        end
        FULL:    if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_instr = main_q[ENTRY_W-1:PC_W];
  assign out_pc8   = main_q[PC_W-1:0];

  // Starvation counter: decode asked for work and nothing was there
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bub_q <= '0;
    end else if (out_ready && !stall && !out_valid && !flush && (bub_q != '1)) begin
      bub_q <= bub_q + CNT_W'(1);
    end
  end

  assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: randomized and directed traffic
// checked against a queue-based reference model, with a scoreboard monitor
// comparing every entry handed to decode.
module tb_if_id_skid_stage;

  localparam int unsigned      INSTR_W = 32;
  localparam int unsigned      PC_W    = 32;
  localparam int unsigned      CNT_W   = 4;
  localparam logic [31:0]      FLUSH_V = 32'h0000_0013;
  localparam int unsigned      CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
  } ent_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr = '0;
  logic [PC_W-1:0]    in_pc8 = '0;
  logic               stall = 1'b0;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc8;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   bubble_cnt;

  if_id_skid_stage #(
    .INSTR_W    (INSTR_W),
    .PC_W       (PC_W),
    .FLUSH_INSTR(FLUSH_V),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc8    (in_pc8),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc8   (out_pc8),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;

  // Reference model: the held entries as a FIFO of depth 2, plus what the
  // output pins currently show and the expected starvation count.
  ent_t        mq[$];
  ent_t        sb_q[$];
  logic [31:0] shown_instr;
  logic [31:0] shown_pc8;
  int          bub;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb_q.delete();
    shown_instr = FLUSH_V;
    shown_pc8   = '0;
    bub         = 0;
  endtask

  task automatic check_state();
    chk("out_valid",  64'(out_valid),  64'(mq.size() > 0));
    chk("in_ready",   64'(in_ready),   64'(mq.size() < 2));
    chk("occupancy",  64'(occupancy),  64'(mq.size()));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(bub));
    chk("out_instr",  64'(out_instr),  64'(shown_instr));
    chk("out_pc8",    64'(out_pc8),    64'(shown_pc8));
  endtask

  // One cycle: check state after the previous edge, drive new inputs and
  // advance the model to what the next edge must produce.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic stl, input logic fl);
    bit   valid_m;
    bit   ready_m;
    ent_t e;
    @(negedge clk);
    check_state();
    #1;
    in_valid  = iv;
    in_instr  = ins;
    in_pc8    = pc;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
    valid_m = (mq.size() > 0);
    ready_m = (mq.size() < 2);
    if (ordy && !stl && !valid_m && !fl && bub < int'(CNT_MAX)) bub++;
    if (fl) begin
      mq.delete();
      shown_instr = FLUSH_V;
    end else begin
      if (valid_m && ordy && !stl) begin
        e = mq.pop_front();
        sb_q.push_back(e);
      end
      if (iv && ready_m) begin
        e.instr = ins;
        e.pc8   = pc;
        mq.push_back(e);
      end
      if (mq.size() > 0) begin
        shown_instr = mq[0].instr;
        shown_pc8   = mq[0].pc8;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every handshake the DUT completes must deliver the
  // oldest outstanding expected entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset && out_valid && out_ready && !stall && !flush) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=%0h/%0h required=none at %0t",
                   out_instr, out_pc8, $time);
        end else begin
          e = sb_q.pop_front();
          chk("pop_instr", 64'(out_instr), 64'(e.instr));
          chk("pop_pc8",   64'(out_pc8),   64'(e.pc8));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    model_reset();
    #22 reset = 1'b1;

    // Starvation counter saturation
    for (int i = 0; i < (1 << CNT_W) + 5; i++) idle(1'b1);
    @(negedge clk);
    chk("bubble_sat", 64'(bubble_cnt), 64'(CNT_MAX));

    // Streaming pass-through
    for (int i = 0; i < 5; i++) step(1'b1, 32'h11 + i, 32'h1000 + 4 * i, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // Backpressure into the skid entry
    step(1'b1, 32'h20, 32'h2000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h21, 32'h2004, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Stall holds the head while a push fills the skid entry
    step(1'b1, 32'h28, 32'h2800, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h29, 32'h2804, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush from FULL with a simultaneous offer that must be discarded
    step(1'b1, 32'h30, 32'h100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h31, 32'h104, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h32, 32'h108, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom, $urandom,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Asynchronous reset while FULL
    step(1'b1, 32'h50, 32'h500, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h51, 32'h504, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_state();
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid",  64'(out_valid),  64'(0));
    chk("rst_out_instr",  64'(out_instr),  64'(FLUSH_V));
    chk("rst_out_pc8",    64'(out_pc8),    64'(0));
    chk("rst_in_ready",   64'(in_ready),   64'(1));
    chk("rst_occupancy",  64'(occupancy),  64'(0));
    chk("rst_bubble_cnt", 64'(bubble_cnt), 64'(0));
    #1 reset = 1'b1;
    step(1'b1, 32'h40, 32'h400, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    check_state();

    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
